// File: rtl/pdua_pkg.sv
// Shared PDUA definitions: flag bit positions in the packed {C,N,P,Z} vector
// and the helper that builds that vector from raw ALU status.
package pdua_pkg;

   localparam int FLAGS_W = 4;
   localparam int FLAG_C  = 3;
   localparam int FLAG_N  = 2;
   localparam int FLAG_P  = 1;
   localparam int FLAG_Z  = 0;

   // P means strictly positive, so it is derived from N and Z, not from the ALU.
   function automatic logic [FLAGS_W-1:0] pack_flags(input logic c, input logic n,
                                                     input logic z);
      logic [FLAGS_W-1:0] f;
      f         = '0;
      f[FLAG_C] = c;
      f[FLAG_N] = n;
      f[FLAG_P] = ~n & ~z;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/status_int_unit_if.sv
// Bundle of control-word strobes, ALU status and condition outputs between
// the datapath/microcode side (master) and status_int_unit (slave).
interface status_int_unit_if #(parameter int DATA_WIDTH = 8);

   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_cout;
   logic                  flag_we;
   logic                  int_en_set;
   logic                  int_en_clr;
   logic                  int_ack;
   logic                  reti;
   logic                  irq;
   logic                  C;
   logic                  N;
   logic                  P;
   logic                  Z;
   logic                  INT;
   logic                  int_pending;

   // All inputs are single-cycle level strobes sampled on the rising clock edge;
   // there is no valid/ready handshake, each strobe acts once per cycle it is high.
   modport master (
      output alu_result, alu_cout, flag_we, int_en_set, int_en_clr, int_ack, reti, irq,
      input  C, N, P, Z, INT, int_pending
   );

   modport slave (
      input  alu_result, alu_cout, flag_we, int_en_set, int_en_clr, int_ack, reti, irq,
      output C, N, P, Z, INT, int_pending
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous external inputs.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign q = sync2_q;

endmodule

// File: rtl/status_int_unit.sv
// Flag register and interrupt front end feeding the PDUA control unit's
// C/N/P/Z/INT condition inputs, with flag save/restore around service.
module status_int_unit
   import pdua_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input logic               clk,
   input logic               rst,
   status_int_unit_if.slave  bus
);

   logic [FLAGS_W-1:0] flags_q, flags_d;
   logic [FLAGS_W-1:0] shadow_q, shadow_d;
   logic               irq_d3_q, irq_d3_d;
   logic               pending_q, pending_d;
   logic               enable_q, enable_d;
   logic               irq_s;
   logic               irq_edge;

   sync_2ff u_irq_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.irq),
      .q   (irq_s)
   );

   assign irq_edge = irq_s & ~irq_d3_q;

   always_comb begin
      flags_d   = flags_q;
      shadow_d  = shadow_q;
      irq_d3_d  = irq_s;
      pending_d = pending_q;
      enable_d  = enable_q;

      if (bus.flag_we)
         flags_d = pack_flags(bus.alu_cout, bus.alu_result[DATA_WIDTH-1],
                              (bus.alu_result == '0));
      if (bus.reti)
         flags_d = shadow_q;

      // Shadow always captures the pre-update flags, even alongside flag_we or reti.
      if (bus.int_ack)
         shadow_d = flags_q;

      if (bus.int_ack)
         pending_d = 1'b0;
      if (irq_edge)
         pending_d = 1'b1;

      // Later assignments win: clearing strobes override the setting ones.
      if (bus.reti)
         enable_d = 1'b1;
      if (bus.int_en_set)
         enable_d = 1'b1;
      if (bus.int_en_clr)
         enable_d = 1'b0;
      if (bus.int_ack)
         enable_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flags_q   <= '0;
         shadow_q  <= '0;
         irq_d3_q  <= 1'b0;
         pending_q <= 1'b0;
         enable_q  <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         shadow_q  <= shadow_d;
         irq_d3_q  <= irq_d3_d;
         pending_q <= pending_d;
         enable_q  <= enable_d;
      end
   end

   assign bus.C           = flags_q[FLAG_C];
   assign bus.N           = flags_q[FLAG_N];
   assign bus.P           = flags_q[FLAG_P];
   assign bus.Z           = flags_q[FLAG_Z];
   assign bus.INT         = pending_q & enable_q;
   assign bus.int_pending = pending_q;

endmodule

// File: tb/tb_status_int_unit.sv
// Directed-vector bench for status_int_unit: flags, interrupt latency,
// shadow save/restore, coincident strobes and asynchronous reset.
module tb_status_int_unit;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   status_int_unit_if #(.DATA_WIDTH(8)) bus ();

   status_int_unit #(.DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] cnpz();
      return {bus.C, bus.N, bus.P, bus.Z};
   endfunction

   // Advance one rising edge and settle; inputs are changed only at this point.
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_strobes();
      bus.flag_we    = 1'b0;
      bus.int_en_set = 1'b0;
      bus.int_en_clr = 1'b0;
      bus.int_ack    = 1'b0;
      bus.reti       = 1'b0;
   endtask

   task automatic load_flags(input logic [7:0] res, input logic cout);
      bus.alu_result = res;
      bus.alu_cout   = cout;
      bus.flag_we    = 1'b1;
      step();
      bus.flag_we    = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.int_ack = 1'b1;
      step();
      bus.int_ack = 1'b0;
   endtask

   task automatic pulse_irq_and_latch();
      bus.irq = 1'b1;
      step(3);
      bus.irq = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      clear_strobes();
      bus.alu_result = 8'h00;
      bus.alu_cout   = 1'b0;
      bus.irq        = 1'b0;
      rst = 1'b0;
      step(3);
      checks++;
      if ({cnpz(), bus.INT, bus.int_pending} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=000000", {cnpz(), bus.INT, bus.int_pending});
      end
      rst = 1'b1;
      step(2);
   endtask

   task automatic test_flags();
      logic [7:0] res_v [3];
      logic       cout_v[3];
      logic [3:0] exp_v [3];
      res_v = '{8'h00, 8'h80, 8'h05};
      cout_v = '{1'b1, 1'b0, 1'b0};
      exp_v = '{4'b1001, 4'b0100, 4'b0010};
      for (int i = 0; i < 3; i++) begin
         load_flags(res_v[i], cout_v[i]);
         checks++;
         if (cnpz() !== exp_v[i]) begin
            errors++;
            $display("FAIL flags_%0d got=%b exp=%b", i, cnpz(), exp_v[i]);
         end
      end
   endtask

   task automatic test_irq_latency();
      logic [2:0] exp_int;
      exp_int = 3'b100;
      bus.int_en_set = 1'b1;
      step();
      bus.int_en_set = 1'b0;
      bus.irq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (bus.INT !== exp_int[i]) begin
            errors++;
            $display("FAIL irq_latency_k%0d got=%b exp=%b", i, bus.INT, exp_int[i]);
         end
      end
      step(3);
      pulse_ack();
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b00) begin
         errors++;
         $display("FAIL irq_ack got=%b exp=00", {bus.INT, bus.int_pending});
      end
      step(4);
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b00) begin
         errors++;
         $display("FAIL irq_held_no_retrigger got=%b exp=00", {bus.INT, bus.int_pending});
      end
      bus.irq = 1'b0;
      step(3);
   endtask

   task automatic test_pending_disabled();
      pulse_irq_and_latch();
      step(4);
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b01) begin
         errors++;
         $display("FAIL pending_disabled got=%b exp=01", {bus.INT, bus.int_pending});
      end
      bus.int_en_set = 1'b1;
      step();
      bus.int_en_set = 1'b0;
      checks++;
      if (bus.INT !== 1'b1) begin
         errors++;
         $display("FAIL pending_then_ei got=%b exp=1", bus.INT);
      end
      pulse_ack();
   endtask

   task automatic test_shadow();
      load_flags(8'h05, 1'b1);
      checks++;
      if (cnpz() !== 4'b1010) begin
         errors++;
         $display("FAIL shadow_setup got=%b exp=1010", cnpz());
      end
      pulse_ack();
      load_flags(8'h00, 1'b0);
      checks++;
      if (cnpz() !== 4'b0001) begin
         errors++;
         $display("FAIL shadow_service_flags got=%b exp=0001", cnpz());
      end
      bus.reti = 1'b1;
      step();
      bus.reti = 1'b0;
      checks++;
      if (cnpz() !== 4'b1010) begin
         errors++;
         $display("FAIL shadow_restore got=%b exp=1010", cnpz());
      end
      pulse_irq_and_latch();
      checks++;
      if (bus.INT !== 1'b1) begin
         errors++;
         $display("FAIL reti_enables got=%b exp=1", bus.INT);
      end
      pulse_ack();
   endtask

   task automatic test_simultaneous();
      // int_ack coinciding with a synchronised irq edge keeps the request.
      bus.int_en_set = 1'b1;
      step();
      bus.int_en_set = 1'b0;
      bus.irq = 1'b1;
      step(2);
      bus.int_ack = 1'b1;
      step();
      bus.int_ack = 1'b0;
      bus.irq = 1'b0;
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b01) begin
         errors++;
         $display("FAIL ack_with_edge got=%b exp=01", {bus.INT, bus.int_pending});
      end
      bus.int_en_set = 1'b1;
      bus.int_en_clr = 1'b1;
      step();
      clear_strobes();
      checks++;
      if (bus.INT !== 1'b0) begin
         errors++;
         $display("FAIL ei_di_together got=%b exp=0", bus.INT);
      end
      bus.int_en_set = 1'b1;
      step();
      bus.int_en_set = 1'b0;
      checks++;
      if (bus.INT !== 1'b1) begin
         errors++;
         $display("FAIL ei_alone got=%b exp=1", bus.INT);
      end
      step(2);
      // reti + flag_we: shadow wins.
      load_flags(8'h80, 1'b1);
      pulse_ack();
      load_flags(8'h00, 1'b0);
      bus.reti = 1'b1;
      bus.flag_we = 1'b1;
      bus.alu_result = 8'h05;
      bus.alu_cout = 1'b0;
      step();
      clear_strobes();
      checks++;
      if (cnpz() !== 4'b1100) begin
         errors++;
         $display("FAIL reti_with_flag_we got=%b exp=1100", cnpz());
      end
      // int_ack + flag_we: shadow gets old flags, live flags get new values.
      bus.int_ack = 1'b1;
      bus.flag_we = 1'b1;
      bus.alu_result = 8'h00;
      bus.alu_cout = 1'b1;
      step();
      clear_strobes();
      checks++;
      if (cnpz() !== 4'b1001) begin
         errors++;
         $display("FAIL ack_with_flag_we got=%b exp=1001", cnpz());
      end
      bus.reti = 1'b1;
      step();
      bus.reti = 1'b0;
      checks++;
      if (cnpz() !== 4'b1100) begin
         errors++;
         $display("FAIL ack_with_flag_we_restore got=%b exp=1100", cnpz());
      end
      // reti + int_ack: live flags from shadow, shadow from live, enable ends 0.
      load_flags(8'h05, 1'b0);
      bus.reti = 1'b1;
      bus.int_ack = 1'b1;
      step();
      clear_strobes();
      checks++;
      if (cnpz() !== 4'b1100) begin
         errors++;
         $display("FAIL reti_with_ack_flags got=%b exp=1100", cnpz());
      end
      pulse_irq_and_latch();
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b01) begin
         errors++;
         $display("FAIL reti_with_ack_enable got=%b exp=01", {bus.INT, bus.int_pending});
      end
      bus.reti = 1'b1;
      step();
      bus.reti = 1'b0;
      checks++;
      if ({cnpz(), bus.INT} !== 5'b00101) begin
         errors++;
         $display("FAIL reti_after_combo got=%b exp=00101", {cnpz(), bus.INT});
      end
   endtask

   task automatic test_reset_mid_service();
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b11) begin
         errors++;
         $display("FAIL mid_service_setup got=%b exp=11", {bus.INT, bus.int_pending});
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({cnpz(), bus.INT, bus.int_pending} !== 6'b0) begin
         errors++;
         $display("FAIL async_reset got=%b exp=000000", {cnpz(), bus.INT, bus.int_pending});
      end
      step(2);
      rst = 1'b1;
      step(6);
      checks++;
      if ({bus.INT, bus.int_pending} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset_no_int got=%b exp=00", {bus.INT, bus.int_pending});
      end
      bus.reti = 1'b1;
      step();
      bus.reti = 1'b0;
      checks++;
      if (cnpz() !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_shadow got=%b exp=0000", cnpz());
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      test_reset();
      test_flags();
      test_irq_latency();
      test_pending_disabled();
      test_shadow();
      test_simultaneous();
      test_reset_mid_service();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
